// File: rtl/alu_seq_unit.sv
// Registered 4-bit-opcode ALU with valid/ready handshakes, a WIDTH-cycle
// sign-magnitude shift-add multiplier and registered zero/negative/overflow flags.
module alu_seq_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output logic                 flag_ovf
);

  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [RW-1:0]    ROne    = RW'(1);
  localparam logic [WIDTH-1:0] WOne    = WIDTH'(1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [CntW-1:0]  CntInit = CntW'(WIDTH);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              sign_q, sign_d;
  logic [RW-1:0]     y_q, y_d;
  logic              zero_q, zero_d;
  logic              negf_q, negf_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [RW-1:0]     as, bs;
  logic [WIDTH-1:0]  a_mag, b_mag, lres;
  logic [RW-1:0]     res;
  logic              res_ovf_en;
  logic              accept, is_mul;
  logic [RW-1:0]     acc_step, prod;
  logic              load, load_ovf_en;
  logic [RW-1:0]     load_res;
  logic [WIDTH:0]    upper;

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (sel == 4'b0101);

  // Single-cycle result datapath.
  always_comb begin
    as         = {{WIDTH{a[WIDTH-1]}}, a};
    bs         = {{WIDTH{b[WIDTH-1]}}, b};
    a_mag      = a[WIDTH-1] ? (~a + WOne) : a;
    b_mag      = b[WIDTH-1] ? (~b + WOne) : b;
    res        = '0;
    lres       = '0;
    res_ovf_en = 1'b0;
    if (!sel[3]) begin
      res_ovf_en = 1'b1;
      case (sel[2:0])
        3'b000: res = as + ROne;
        3'b001: res = bs + ROne;
        3'b010: begin res = as; res_ovf_en = 1'b0; end
        3'b011: begin res = bs; res_ovf_en = 1'b0; end
        3'b100: res = as - ROne;
        3'b101: res = '0;  // produced by the multiplier
        3'b110: res = as + bs;
        default: res = as - bs;
      endcase
    end else begin
      case (sel[2:0])
        3'b000: lres = ~a;
        3'b001: lres = ~b;
        3'b010: lres = a & b;
        3'b011: lres = a | b;
        3'b100: lres = a ^ b;
        3'b101: lres = ~(a ^ b);
        3'b110: lres = ~(a & b);
        default: lres = ~(a | b);
      endcase
      res = {{WIDTH{1'b0}}, lres};
    end
  end

  // Multiplier step on magnitudes; sign applied on the final iteration.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = sign_q ? (~acc_step + ROne) : acc_step;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    sign_d      = sign_q;
    y_d         = y_q;
    zero_d      = zero_q;
    negf_d      = negf_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    load        = 1'b0;
    load_res    = '0;
    load_ovf_en = 1'b0;
    upper       = '0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = StMul;
            cnt_d    = CntInit;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
          end else begin
            load        = 1'b1;
            load_res    = res;
            load_ovf_en = res_ovf_en;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          load        = 1'b1;
          load_res    = prod;
          load_ovf_en = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      // In range iff the top WIDTH+1 bits are all equal.
      upper       = load_res[RW-1:WIDTH-1];
      y_d         = load_res;
      out_valid_d = 1'b1;
      zero_d      = (load_res == '0);
      negf_d      = load_res[RW-1];
      ovf_d       = load_ovf_en && !((&upper) || !(|upper));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sign_q      <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      negf_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sign_q      <= sign_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      negf_q      <= negf_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign flag_zero = zero_q;
  assign flag_neg  = negf_q;
  assign flag_ovf  = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit at WIDTH=4: directed vector table,
// handshake/reset sequences and random ops against an integer reference model.
module tb_alu_seq_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       flag_zero;
  logic       flag_neg;
  logic       flag_ovf;

  int checks;
  int failures;

  alu_seq_unit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .flag_ovf  (flag_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic [7:0] y;
    logic       z;
    logic       n;
    logic       o;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on the operand values.
  task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic [3:0] ms,
                       output logic [7:0] my, output logic mz, output logic mn,
                       output logic mo);
    int sa;
    int sb;
    int r;
    logic [3:0] l;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = 0;
    l  = '0;
    mo = 1'b0;
    if (!ms[3]) begin
      case (ms[2:0])
        3'd0: r = sa + 1;
        3'd1: r = sb + 1;
        3'd2: r = sa;
        3'd3: r = sb;
        3'd4: r = sa - 1;
        3'd5: r = sa * sb;
        3'd6: r = sa + sb;
        default: r = sa - sb;
      endcase
      my = r[7:0];
      mo = (ms[2:0] != 3'd2) && (ms[2:0] != 3'd3) && ((r < -8) || (r > 7));
    end else begin
      case (ms[2:0])
        3'd0: l = ~ma;
        3'd1: l = ~mb;
        3'd2: l = ma & mb;
        3'd3: l = ma | mb;
        3'd4: l = ma ^ mb;
        3'd5: l = ~(ma ^ mb);
        3'd6: l = ~(ma & mb);
        default: l = ~(ma | mb);
      endcase
      my = {4'b0000, l};
    end
    mz = (my == 8'h00);
    mn = my[7];
  endtask

  // Issue one op with out_ready=1; returns negedges until out_valid and
  // how many of those showed in_ready low.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_b, input logic [3:0] ts,
                        output int lat, output int busy);
    @(negedge clk);
    a = ta;
    b = tb_b;
    sel = ts;
    in_valid = 1'b1;
    check("in_ready_at_issue", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    sel = 4'($urandom_range(0, 15));
    lat = 0;
    busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) busy++;
    end while (!out_valid && lat < 20);
  endtask

  logic [7:0] ey;
  logic       ez, en, eo;
  int         lat, busy, idle_cnt;
  logic [3:0] sa_q[8], sb_q[8], ss_q[8];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sel = '0;

    vecs[0]  = '{4'h7, 4'h3, 4'b0110, 8'h0A, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{4'h2, 4'h5, 4'b0111, 8'hFD, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'h8, 4'h0, 4'b0100, 8'hF7, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{4'h8, 4'h8, 4'b0101, 8'h40, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{4'h3, 4'hE, 4'b0101, 8'hFA, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'hC, 4'hA, 4'b1110, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'hC, 4'hA, 4'b1000, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'h0, 4'hA, 4'b1010, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'h0, 4'h5, 4'b0010, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'h7, 4'h0, 4'b0000, 8'h08, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'h5, 4'h6, 4'b1100, 8'h03, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_y", y, 8'h00);
    check("reset_flags", {flag_zero, flag_neg, flag_ovf}, 3'b000);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, lat, busy);
      check("vec_y", y, vecs[i].y);
      check("vec_flags", {flag_zero, flag_neg, flag_ovf}, {vecs[i].z, vecs[i].n, vecs[i].o});
      check("vec_latency", lat, (vecs[i].sel == 4'b0101) ? 5 : 1);
      check("vec_busy_cycles", busy, (vecs[i].sel == 4'b0101) ? 4 : 0);
    end

    // Backpressure: result held, next op stalled, then drain+accept on one edge.
    @(negedge clk);
    out_ready = 1'b0;
    a = 4'h1; b = 4'h2; sel = 4'b0110; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 4'h3; b = 4'h3; sel = 4'b0110;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_y_hold", y, 8'h03);
      check("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_y", y, 8'h06);
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Stream of 8 single-cycle ops, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      sa_q[i] = 4'($urandom_range(0, 15));
      sb_q[i] = 4'($urandom_range(0, 15));
      ss_q[i] = 4'($urandom_range(0, 15));
      if (ss_q[i] == 4'b0101) ss_q[i] = 4'b0110;
    end
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        model(sa_q[i-1], sb_q[i-1], ss_q[i-1], ey, ez, en, eo);
        check("stream_valid", out_valid, 1);
        check("stream_y", y, ey);
        check("stream_flags", {flag_zero, flag_neg, flag_ovf}, {ez, en, eo});
      end
      if (i < 8) begin
        a = sa_q[i]; b = sb_q[i]; sel = ss_q[i]; in_valid = 1'b1;
        check("stream_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Reset two cycles into a multiply.
    run_op(4'h1, 4'h2, 4'b0110, lat, busy);
    check("pre_rst_y", y, 8'h03);
    @(negedge clk);
    a = 4'h3; b = 4'h3; sel = 4'b0101; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_mul_y", y, 8'h00);
    check("rst_mid_mul_valid", out_valid, 0);
    check("rst_mid_mul_flags", {flag_zero, flag_neg, flag_ovf}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    idle_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || !in_ready) idle_cnt++;
    end
    check("post_rst_no_result", idle_cnt, 0);
    run_op(4'h1, 4'h1, 4'b0110, lat, busy);
    check("post_rst_add_y", y, 8'h02);
    check("post_rst_add_lat", lat, 1);

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] ra, rb, rs;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15));
      model(ra, rb, rs, ey, ez, en, eo);
      run_op(ra, rb, rs, lat, busy);
      check("rand_y", y, ey);
      check("rand_flags", {flag_zero, flag_neg, flag_ovf}, {ez, en, eo});
      check("rand_latency", lat, (rs == 4'b0101) ? 5 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same 4-bit `sel` opcode map and the same signed 2×WIDTH result, and adds:
- valid/ready handshakes on input and output;
- a multi-cycle shift-add multiplier;
- registered zero/negative/overflow flags.

It sits between an operand-issue stage and a result consumer, and allows one operation in flight.

## Interface
- `WIDTH`, default 4: operand width in bits, ≥ 2; result width is 2*WIDTH.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: operands and `sel` are valid.
- `in_ready` output 1: unit accepts an operation this cycle; combinational.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `sel` input 4: opcode, with `sel[3]` = 0 arithmetic, 1 logic.
- `out_valid` output 1: `y` and the flags hold a result.
- `out_ready` input 1: consumer takes the result this cycle.
- `y` output 2*WIDTH: signed result, registered.
- `flag_zero` output 1: `y` == 0.
- `flag_neg` output 1: `y[2*WIDTH-1]`.
- `flag_ovf` output 1: arithmetic result is outside the WIDTH-bit signed range [-2^(WIDTH-1), 2^(WIDTH-1)-1].

## Operation
- Accept occurs when `in_valid` && `in_ready`. `a`, `b` and `sel` are captured at that edge. Inputs are ignored at all other times.
- Arithmetic (`sel[3]`=0): `a` and `b` are sign-extended to 2*WIDTH (As, Bs). Results are exact in 2*WIDTH bits.
  - 000: As+1
  - 001: Bs+1
  - 010: As
  - 011: Bs
  - 100: As-1
  - 101: As*Bs (multi-cycle)
  - 110: As+Bs
  - 111: As-Bs
- Logic (`sel[3]`=1): computed on WIDTH bits and zero-extended into `y`; upper WIDTH bits are 0.
  - 000: ~a
  - 001: ~b
  - 010: a&b
  - 011: a|b
  - 100: a^b
  - 101: ~(a^b)
  - 110: ~(a&b)
  - 111: ~(a|b)
- Flags are registered together with `y`.
  - `flag_ovf` is 0 for logic ops and for pass-through (010, 011).
- State machine:
  - IDLE: on accept of a non-multiply op, load `y` and flags and set `out_valid`; stay in IDLE. On accept of a multiply, go to MUL, load the iteration counter with WIDTH and clear the accumulator.
  - MUL: exactly one shift-add iteration per cycle; the counter decrements each cycle. On the final iteration, load `y` with the exact signed product, load the flags, set `out_valid`, and go to IDLE. The internal algorithm (sign-magnitude or Booth) is implementer's choice; the iteration count is fixed.
- `in_ready` = (state == IDLE) && (!`out_valid` || `out_ready`).
- `out_valid` clears on `out_ready` unless a new result loads in the same cycle; a new result takes priority.
- Output hold: `y` and the flags are stable while `out_valid` && !`out_ready`.

## Timing
- Reset values: `y`=0, all flags 0, `out_valid`=0, state IDLE, counter 0. `in_ready`=1 once `rst` deasserts.
- Single-cycle ops:
  - Accept at edge k gives `out_valid`=1 after edge k.
  - Back-to-back throughput is 1 op/cycle while `out_ready`=1.
- Multiply:
  - Accept at edge k gives `out_valid`=1 after edge k+WIDTH.
  - `in_ready`=0 for the WIDTH cycles in MUL.
- Simultaneous drain and accept (`out_valid`, `out_ready` and `in_valid` all high in IDLE): the old result is consumed and the new result loads at the same edge, with no bubble.
- Reset mid-MUL aborts the operation: no result is produced and the unit returns to IDLE.
- Extreme values: multiply of -2^(WIDTH-1) by -2^(WIDTH-1) yields +2^(2*WIDTH-2) with no wrap.

## Test plan
- WIDTH=4, `a`=7, `b`=3, `sel`=0110 → one cycle later `y`=0x0A, `flag_ovf`=1, `flag_neg`=0, `flag_zero`=0.
- `a`=2, `b`=5, `sel`=0111 → `y`=0xFD, `flag_neg`=1, `flag_ovf`=0. Also `a`=0x8, `sel`=0100 → `y`=0xF7, `flag_ovf`=1.
- `a`=0x8, `b`=0x8, `sel`=0101 → `in_ready` low for 4 cycles, then `y`=0x40, `flag_ovf`=1. Also `a`=0x3, `b`=0xE → `y`=0xFA, `flag_ovf`=0.
- `a`=1100, `b`=1010 for `sel`=1110 → `y`=0x07; for `sel`=1000 → `y`=0x03; for `sel`=1010 with `a`=0 → `y`=0x00, `flag_zero`=1, `flag_ovf`=0.
- Backpressure: hold `out_ready`=0 with `in_valid`=1 → `y` stable and `in_ready`=0. Then raise `out_ready` → old result consumed and next result loaded on the same edge. A stream of 8 single-cycle ops with `out_ready`=1 completes in 8 cycles.
- Assert `rst` 2 cycles into a multiply → `out_valid`, `y` and the flags go to 0 immediately. After release, `in_ready`=1 and a fresh add of 1+1 returns `y`=0x02.
